// File: rtl/spi_rx_deser.sv
// spi_rx_deser: MSB-first serial receiver, async pins synchronised onto clk.
// Optional mid-word idle timeout enabled by defining SPI_RX_TIMEOUT_EN.
module spi_rx_deser #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_clock,
    input  logic             serial_in,
    input  logic             cs_n,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic             aborted
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("spi_rx_deser: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sin_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic                   sclk_q;

    logic                   sclk_s;
    logic                   sin_s;
    logic                   csn_s;
    logic                   edge_det;

    state_t                 state;
    logic [CW-1:0]          bit_cnt;
    logic [WIDTH-1:0]       shreg;
    logic [WIDTH-1:0]       shreg_nxt;
    logic                   last_bit;
    logic                   tmo_hit;

    logic [WIDTH-1:0]       word_q;
    logic                   word_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            sin_sync  <= '0;
            csn_sync  <= '0;
            sclk_q    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], serial_clock};
            sin_sync  <= {sin_sync[SYNC_STAGES-2:0], serial_in};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], cs_n};
            sclk_q    <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sin_s     = sin_sync[SYNC_STAGES-1];
    assign csn_s     = csn_sync[SYNC_STAGES-1];
    assign edge_det  = sclk_s & ~sclk_q;
    assign shreg_nxt = {shreg[WIDTH-2:0], sin_s};
    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

`ifdef SPI_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] idle_cnt;
    logic          idle_run;

    // Counts only while a partial word is held and no edge arrives.
    assign idle_run = (state == SHIFT) && !csn_s && !edge_det
                      && (bit_cnt != '0);
    assign tmo_hit  = idle_run && (idle_cnt == IW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!idle_run || tmo_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            word_q    <= '0;
            word_done <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            word_done <= 1'b0;
            aborted   <= 1'b0;
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                    if (!csn_s) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs_n deassertion outranks a coincident serial edge
                    if (csn_s) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        aborted <= (bit_cnt != '0);
                    end else if (edge_det) begin
                        shreg <= shreg_nxt;
                        if (last_bit) begin
                            bit_cnt   <= '0;
                            word_q    <= shreg_nxt;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                        aborted <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A read in the completion cycle frees the slot for the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!data_valid || rd_en) begin
                    data_out   <= word_q;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rd_en) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_deser.sv
// tb_spi_rx_deser: randomized stimulus, scoreboard of expected word/overrun/abort
// events built from a bit-level frame model, monitor compares DUT outputs.
module tb_spi_rx_deser;

    localparam int W  = 8;
    localparam int SS = 2;
`ifdef SPI_RX_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         serial_clock = 1'b0;
    logic         serial_in = 1'b0;
    logic         cs_n = 1'b1;
    logic         mon_rd = 1'b0;
    logic         drv_rd = 1'b0;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         overrun;
    logic         aborted;

    assign rd_en = mon_rd | drv_rd;

    spi_rx_deser #(
        .WIDTH(W),
        .SYNC_STAGES(SS),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .serial_clock(serial_clock),
        .serial_in(serial_in),
        .cs_n(cs_n),
        .rd_en(rd_en),
        .data_out(data_out),
        .data_valid(data_valid),
        .overrun(overrun),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    // kind: 0 = word, 1 = overrun, 2 = abort
    typedef struct {
        int           kind;
        logic [W-1:0] data;
    } ev_t;

    ev_t          expq[$];
    int           checks = 0;
    int           errors = 0;
    bit           auto_rd = 1'b0;
    bit           mdl_valid = 1'b0;
    bit           rd_same = 1'b0;
    int           nbits = 0;
    logic [W-1:0] acc = '0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [W-1:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic expect_ev(input int k, input logic [W-1:0] d,
                             input string nm);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL %s act=kind%0d/%0h exp=none", nm, k, d);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.data !== d) begin
                errors++;
                $display("FAIL %s act=kind%0d/%0h exp=kind%0d/%0h",
                         nm, k, d, e.kind, e.data);
            end
        end
    endtask

    // Frame model: every W accepted bits make a word, value = bits read MSB first.
    task automatic mdl_bit(input bit b);
        acc = (acc << 1) | W'(b);
        nbits++;
        if (nbits == W) begin
            nbits = 0;
            if (mdl_valid && !rd_same) begin
                push(1, '0);
            end else begin
                push(0, acc);
                mdl_valid = !auto_rd;
            end
        end
    endtask

    task automatic mdl_drop();
        if (nbits != 0) push(2, '0);
        nbits = 0;
        acc = '0;
    endtask

    // mode 0: plain, 1: check latency of last bit, 2: read in completion cycle
    task automatic send_bits(input logic [W-1:0] v, input int n,
                             input int h, input int mode);
        for (int i = n - 1; i >= 0; i--) begin
            serial_in = v[i];
            tick(h);
            serial_clock = 1'b1;
            rd_same = (i == 0 && mode == 2);
            mdl_bit(v[i]);
            rd_same = 1'b0;
            if (i == 0 && mode != 0) begin
                tick(SS + 1);
                if (mode == 1) chk("lat_early", data_valid, 0);
                else drv_rd = 1'b1;
                tick(1);
                drv_rd = 1'b0;
                if (mode == 1) begin
                    chk("lat_valid", data_valid, 1);
                    chk("lat_data", data_out, v);
                end
                tick(h - SS - 2);
            end else begin
                tick(h);
            end
            serial_clock = 1'b0;
        end
    endtask

    task automatic drv_pop();
        drv_rd = 1'b1;
        tick(1);
        drv_rd = 1'b0;
        mdl_valid = 1'b0;
        tick(1);
    endtask

    initial begin : monitor
        bit vp;
        bit rp;
        bit nw;
        vp = 1'b0;
        rp = 1'b0;
        forever begin
            @(negedge clk);
            nw = data_valid && (!vp || rp);
            if (aborted) expect_ev(2, '0, "aborted");
            if (overrun) expect_ev(1, '0, "overrun");
            if (nw) expect_ev(0, data_out, "word");
            vp = data_valid;
            if (mon_rd) mon_rd = 1'b0;
            else if (auto_rd && nw) mon_rd = 1'b1;
            rp = mon_rd | drv_rd;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        tick(3);
        chk("rst_data", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_abt", aborted, 0);
        rst_n = 1'b1;
        tick(4);

        // single word, exact latency
        cs_n = 1'b0;
        tick(4);
        send_bits(8'hA5, W, 6, 1);
        tick(3);
        drv_pop();
        chk("pop_valid", data_valid, 0);

        // back-to-back without read: second word dropped
        send_bits(8'h3C, W, 4, 0);
        send_bits(8'hC3, W, 4, 0);
        tick(6);
        chk("ovr_hold", data_out, 8'h3C);
        chk("ovr_valid", data_valid, 1);
        drv_pop();

        // read coincides with completion: new word loads
        send_bits(8'h3C, W, 6, 0);
        send_bits(8'hC3, W, 6, 2);
        tick(3);
        chk("rdsame_data", data_out, 8'hC3);
        chk("rdsame_valid", data_valid, 1);
        drv_pop();

        // partial frame aborted by cs_n, then clean frame
        auto_rd = 1'b1;
        send_bits(8'h15, 5, 4, 0);
        cs_n = 1'b1;
        mdl_drop();
        tick(6);
        chk("abt_valid", data_valid, 0);
        cs_n = 1'b0;
        tick(4);
        send_bits(8'h81, W, 4, 0);
        tick(6);
        chk("abt_next", data_out, 8'h81);

        // reset mid-word with an unread word held
        auto_rd = 1'b0;
        send_bits(8'h66, W, 4, 0);
        send_bits(8'h09, 4, 4, 0);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_valid", data_valid, 0);
        chk("mid_rst_ovr", overrun, 0);
        chk("mid_rst_abt", aborted, 0);
        nbits = 0;
        acc = '0;
        mdl_valid = 1'b0;
        tick(3);
        rst_n = 1'b1;
        auto_rd = 1'b1;
        tick(4);
        send_bits(8'hFF, W, 4, 0);
        tick(6);
        chk("post_rst", data_out, 8'hFF);

        // transmitter stalls mid-word
        send_bits(8'h05, 3, 4, 0);
        tick(TMO + 10);
`ifdef SPI_RX_TIMEOUT_EN
        mdl_drop();
        send_bits(8'h5A, W, 4, 0);
        tick(6);
        chk("tmo_next", data_out, 8'h5A);
`else
        send_bits(8'h1A, 5, 4, 0);
        tick(6);
        chk("stall_join", data_out, 8'hBA);
`endif

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            int h;
            h = $urandom_range(3, 6);
            if ($urandom_range(0, 4) == 0) begin
                send_bits(W'($urandom), $urandom_range(1, W - 1), h, 0);
                cs_n = 1'b1;
                mdl_drop();
                tick($urandom_range(4, 8));
                cs_n = 1'b0;
                tick(4);
            end else begin
                int nw;
                nw = $urandom_range(1, 3);
                for (int k = 0; k < nw; k++) begin
                    send_bits(W'($urandom), W, h, 0);
                end
                if ($urandom_range(0, 1) == 1) begin
                    tick(2);
                    cs_n = 1'b1;
                    mdl_drop();
                    tick(5);
                    cs_n = 1'b0;
                    tick(4);
                end
            end
        end

        tick(20);
        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
